// File: rtl/mdu_iter.sv
// -----------------------------------------------------------------------------
// mdu_iter -- iterative integer multiply/divide unit (RV64M/RV32M style).
//
// Multiplication is radix-2 shift-add on operand magnitudes. Division is
// radix-2 restoring on magnitudes. Either one takes N CALC cycles, where
// N = 32 for word ops and XLEN otherwise. Signs are fixed up in the last
// cycle. Divide-by-zero and signed overflow skip CALC and finish one cycle
// after accept.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_valid / o_ready         request handshake (o_ready only in IDLE)
//   i_op[2:0]                 0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//   i_word                    32-bit W variant (XLEN=64, ops 0/4/5/6/7 only)
//   i_rs1_rdata, i_rs2_rdata  operands
//   i_rd_addr                 destination tag, captured at accept
//   i_flush                   abort; beats accept and i_ready
//   o_valid / i_ready         result handshake (o_valid only in DONE)
//   o_rd_data, o_rd_addr      result and its tag, held stable while stalled
// -----------------------------------------------------------------------------
module mdu_iter #(
    parameter int XLEN = 64,
    parameter int RD_W = 5
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic            i_word,
    input  logic [XLEN-1:0] i_rs1_rdata,
    input  logic [XLEN-1:0] i_rs2_rdata,
    input  logic [RD_W-1:0] i_rd_addr,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_rd_data,
    output logic [RD_W-1:0] o_rd_addr
);

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam int DW    = 2 * XLEN;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    localparam logic [XLEN-1:0] MASK_W = XLEN'(64'h0000_0000_FFFF_FFFF);
    localparam logic [XLEN-1:0] MIN_X  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES_X = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO_X = {XLEN{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Sign-extend bit 31 across the upper bits (identity when XLEN = 32).
    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
        logic [XLEN-1:0] r;
        r = x;
        for (int i = 32; i < XLEN; i++) begin
            r[i] = x[31];
        end
        return r;
    endfunction

    // Conditional two's complement negate.
    function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] x);
        return n ? (~x + XLEN'(1'b1)) : x;
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic               word_q, word_d;
    logic               sa_q, sa_d;      // operand 1 was negative (signed op)
    logic               sb_q, sb_d;      // operand 2 was negative (signed op)
    logic [DW-1:0]      a_q, a_d;        // mul accumulator / div partial remainder
    logic [DW-1:0]      b_q, b_d;        // shifted multiplicand / divisor magnitude
    logic [XLEN-1:0]    c_q, c_d;        // multiplier / dividend shifting into quotient
    logic [XLEN-1:0]    res_q, res_d;
    logic [RD_W-1:0]    rd_q, rd_d;

    // Request decode, evaluated on the accept cycle only.
    logic            word_in_s, sgn_a_in_s, sgn_b_in_s, sa_in_s, sb_in_s;
    logic [XLEN-1:0] rs1_eff_s, rs2_eff_s, mag_a_raw_s, mag_b_raw_s;
    logic [XLEN-1:0] mag_a_s, mag_b_s, rs1_sx_s, byp_res_s;
    logic            dz_s, ovf_s;

    // Per-iteration datapath and final sign fix-up.
    logic [DW-1:0]   mul_acc_s, mul_prod_s;
    logic [XLEN:0]   div_shift_s, div_diff_s;
    logic            div_qbit_s;
    logic [XLEN-1:0] div_rem_s, div_quo_s, quo_fix_s, rem_fix_s, div_sel_s;
    logic [XLEN-1:0] mul_res_s, div_res_s, fin_res_s;

    // Decode of the incoming request: effective width, magnitudes, bypass cases.
    always_comb begin
        word_in_s  = (XLEN == 64) && i_word && ((i_op == OP_MUL) || i_op[2]);
        sgn_a_in_s = (i_op == OP_MUL) || (i_op == OP_MULH) || (i_op == OP_MULHSU) ||
                     (i_op == OP_DIV) || (i_op == OP_REM);
        sgn_b_in_s = (i_op == OP_MUL) || (i_op == OP_MULH) ||
                     (i_op == OP_DIV) || (i_op == OP_REM);
        rs1_eff_s  = word_in_s ? (i_rs1_rdata & MASK_W) : i_rs1_rdata;
        rs2_eff_s  = word_in_s ? (i_rs2_rdata & MASK_W) : i_rs2_rdata;
        sa_in_s    = sgn_a_in_s && (word_in_s ? i_rs1_rdata[31] : i_rs1_rdata[XLEN-1]);
        sb_in_s    = sgn_b_in_s && (word_in_s ? i_rs2_rdata[31] : i_rs2_rdata[XLEN-1]);
        // Negating a zero-extended word sets upper bits; mask back to 32.
        mag_a_raw_s = neg_if(sa_in_s, rs1_eff_s);
        mag_b_raw_s = neg_if(sb_in_s, rs2_eff_s);
        mag_a_s    = word_in_s ? (mag_a_raw_s & MASK_W) : mag_a_raw_s;
        mag_b_s    = word_in_s ? (mag_b_raw_s & MASK_W) : mag_b_raw_s;
        rs1_sx_s   = word_in_s ? sext32(i_rs1_rdata) : i_rs1_rdata;
        dz_s       = (rs2_eff_s == ZERO_X);
        if (word_in_s) begin
            ovf_s = ((i_op == OP_DIV) || (i_op == OP_REM)) &&
                    (i_rs1_rdata[31:0] == 32'h8000_0000) &&
                    (i_rs2_rdata[31:0] == 32'hFFFF_FFFF);
        end else begin
            ovf_s = ((i_op == OP_DIV) || (i_op == OP_REM)) &&
                    (i_rs1_rdata == MIN_X) && (i_rs2_rdata == ONES_X);
        end
        // i_op[1] separates remainder ops (6,7) from quotient ops (4,5).
        if (dz_s) begin
            byp_res_s = i_op[1] ? rs1_sx_s : ONES_X;
        end else begin
            byp_res_s = i_op[1] ? ZERO_X : rs1_sx_s;
        end
    end

    // One shift-add / restoring-divide step plus the final-cycle result.
    always_comb begin
        mul_acc_s   = a_q + (c_q[0] ? b_q : {DW{1'b0}});
        div_shift_s = {a_q[XLEN-1:0], c_q[XLEN-1]};
        div_diff_s  = div_shift_s - {1'b0, b_q[XLEN-1:0]};
        div_qbit_s  = ~div_diff_s[XLEN];
        div_rem_s   = div_qbit_s ? div_diff_s[XLEN-1:0] : div_shift_s[XLEN-1:0];
        div_quo_s   = {c_q[XLEN-2:0], div_qbit_s};

        mul_prod_s  = (sa_q ^ sb_q) ? (~mul_acc_s + DW'(1'b1)) : mul_acc_s;
        if (op_q == OP_MUL) begin
            mul_res_s = word_q ? sext32(mul_prod_s[XLEN-1:0]) : mul_prod_s[XLEN-1:0];
        end else begin
            mul_res_s = mul_prod_s[DW-1:XLEN];
        end

        quo_fix_s = neg_if(sa_q ^ sb_q, div_quo_s);
        rem_fix_s = neg_if(sa_q, div_rem_s);
        div_sel_s = op_q[1] ? rem_fix_s : quo_fix_s;
        div_res_s = word_q ? sext32(div_sel_s) : div_sel_s;
        fin_res_s = op_q[2] ? div_res_s : mul_res_s;
    end

    // FSM next-state and register next values; flush has top priority.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        word_d  = word_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        res_d   = res_q;
        rd_d    = rd_q;
        case (state_q)
            S_IDLE: begin
                if (i_flush) begin
                    state_d = S_IDLE;
                end else if (i_valid) begin
                    op_d   = i_op;
                    word_d = word_in_s;
                    sa_d   = sa_in_s;
                    sb_d   = sb_in_s;
                    rd_d   = i_rd_addr;
                    cnt_d  = word_in_s ? CNT_W'(32) : CNT_W'(XLEN);
                    a_d    = {DW{1'b0}};
                    if (i_op[2]) begin
                        b_d = {ZERO_X, mag_b_s};
                        // Word dividends are top-aligned so the MSB-first walk
                        // always starts at bit XLEN-1.
                        c_d = word_in_s ? (mag_a_s << (XLEN - 32)) : mag_a_s;
                    end else begin
                        b_d = {ZERO_X, mag_a_s};
                        c_d = mag_b_s;
                    end
                    if (i_op[2] && (dz_s || ovf_s)) begin
                        res_d   = byp_res_s;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (i_flush) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (op_q[2]) begin
                        a_d = {ZERO_X, div_rem_s};
                        c_d = div_quo_s;
                    end else begin
                        a_d = mul_acc_s;
                        b_d = {b_q[DW-2:0], 1'b0};
                        c_d = {1'b0, c_q[XLEN-1:1]};
                    end
                    if (cnt_q == CNT_W'(1)) begin
                        res_d   = fin_res_s;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_DONE: begin
                if (i_flush || i_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            op_q    <= 3'd0;
            word_q  <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            a_q     <= {DW{1'b0}};
            b_q     <= {DW{1'b0}};
            c_q     <= ZERO_X;
            res_q   <= ZERO_X;
            rd_q    <= {RD_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            word_q  <= word_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            res_q   <= res_d;
            rd_q    <= rd_d;
        end
    end

    assign o_ready   = (state_q == S_IDLE);
    assign o_valid   = (state_q == S_DONE);
    assign o_rd_data = res_q;
    assign o_rd_addr = rd_q;

endmodule

// File: tb/tb_mdu_iter.sv
// -----------------------------------------------------------------------------
// tb_mdu_iter -- directed bench for mdu_iter at XLEN=64.
// A table of {op, word, rs1, rs2, expected result, expected latency} records
// is applied in a loop; latency counts edges from the accept edge (inclusive)
// to the first cycle with o_valid. Hand-written sequences then cover flush
// mid-CALC, a stalled DONE, flush in DONE and reset mid-CALC.
// -----------------------------------------------------------------------------
module tb_mdu_iter;

    localparam int XLEN = 64;
    localparam int RD_W = 5;

    logic            i_clk;
    logic            i_rst_n;
    logic            i_valid;
    logic            o_ready;
    logic [2:0]      i_op;
    logic            i_word;
    logic [XLEN-1:0] i_rs1_rdata;
    logic [XLEN-1:0] i_rs2_rdata;
    logic [RD_W-1:0] i_rd_addr;
    logic            i_flush;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_rd_data;
    logic [RD_W-1:0] o_rd_addr;

    mdu_iter #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_op        (i_op),
        .i_word      (i_word),
        .i_rs1_rdata (i_rs1_rdata),
        .i_rs2_rdata (i_rs2_rdata),
        .i_rd_addr   (i_rd_addr),
        .i_flush     (i_flush),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_rd_data   (o_rd_data),
        .o_rd_addr   (o_rd_addr)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [2:0]  op;
        logic        word;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void add(input logic [2:0] op, input logic w,
                                input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] e, input int lat);
        vec_t v;
        v.op = op; v.word = w; v.rs1 = a; v.rs2 = b; v.exp = e; v.lat = lat;
        vecs.push_back(v);
    endfunction

    function automatic void check(input string name, input logic [63:0] got,
                                  input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endfunction

    // Present a request for one edge, then scramble the request inputs.
    task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [RD_W-1:0] rd);
        check("ready_before_issue", {63'd0, o_ready}, 64'd1);
        i_valid = 1'b1; i_op = op; i_word = w;
        i_rs1_rdata = a; i_rs2_rdata = b; i_rd_addr = rd;
        @(posedge i_clk); #1;
        i_valid     = 1'b0;
        i_op        = 3'($urandom_range(0, 7));
        i_word      = 1'($urandom_range(0, 1));
        i_rs1_rdata = {$urandom, $urandom};
        i_rs2_rdata = {$urandom, $urandom};
        i_rd_addr   = RD_W'($urandom_range(0, 31));
    endtask

    // Latency in edges, counting the accept edge as 1; capped at 200.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!o_valid && lat < 200) begin
            @(posedge i_clk); #1;
            lat++;
        end
    endtask

    task automatic handoff();
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        check("valid_after_handoff", {63'd0, o_valid}, 64'd0);
    endtask

    initial begin
        int          lat;
        logic [63:0] held_data;
        logic        saw_valid;

        i_rst_n = 1'b0; i_valid = 1'b0; i_op = 3'd0; i_word = 1'b0;
        i_rs1_rdata = 64'd0; i_rs2_rdata = 64'd0; i_rd_addr = 5'd0;
        i_flush = 1'b0; i_ready = 1'b0;

        // op, word, rs1, rs2, expected, latency
        add(3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 65);
        add(3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        add(3'd4, 1'b0, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        add(3'd6, 1'b0, 64'd7, 64'd0, 64'd7, 1);
        add(3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
        add(3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
        add(3'd4, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
        add(3'd6, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        add(3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd0, 65);
        add(3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        add(3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 65);
        add(3'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd0, 65);
        add(3'd1, 1'b0, 64'h4000_0000_0000_0000, 64'd4, 64'd1, 65);
        add(3'd0, 1'b1, 64'h1234_5678_0001_0000, 64'hABCD_0000_0000_8000, 64'hFFFF_FFFF_8000_0000, 33);
        add(3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65);
        add(3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 65);
        add(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65);
        add(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        add(3'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 65);
        add(3'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF, 65);
        add(3'd5, 1'b1, 64'h0000_0005_8000_0000, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        add(3'd7, 1'b1, 64'h0000_0005_8000_0000, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_8000_0000, 1);
        add(3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
        add(3'd5, 1'b1, 64'hFFFF_FFFF_0000_0064, 64'd10, 64'd10, 33);

        // Reset state
        @(posedge i_clk); #1;
        check("rst_valid", {63'd0, o_valid}, 64'd0);
        check("rst_data", o_rd_data, 64'd0);
        check("rst_addr", {59'd0, o_rd_addr}, 64'd0);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        check("rst_ready", {63'd0, o_ready}, 64'd1);
        check("rst_valid_after", {63'd0, o_valid}, 64'd0);

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].op, vecs[i].word, vecs[i].rs1, vecs[i].rs2, RD_W'(i + 1));
            wait_valid(lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("vec%0d_data", i), o_rd_data, vecs[i].exp);
            check($sformatf("vec%0d_addr", i), {59'd0, o_rd_addr}, 64'(i + 1));
            handoff();
        end

        // Flush in cycle T+10 of a DIVU; flush also beats a concurrent accept.
        issue(3'd5, 1'b0, 64'd1000, 64'd3, 5'd9);
        repeat (9) begin @(posedge i_clk); #1; end
        check("flush_busy_before", {63'd0, o_ready}, 64'd0);
        i_flush = 1'b1; i_valid = 1'b1; i_op = 3'd5; i_rs2_rdata = 64'd0;
        @(posedge i_clk); #1;
        check("flush_ready_t11", {63'd0, o_ready}, 64'd1);
        check("flush_valid_t11", {63'd0, o_valid}, 64'd0);
        @(posedge i_clk); #1;
        check("flush_beats_accept", {63'd0, o_ready}, 64'd1);
        i_flush = 1'b0; i_valid = 1'b0;
        saw_valid = 1'b0;
        repeat (80) begin
            @(posedge i_clk); #1;
            saw_valid = saw_valid | o_valid;
        end
        check("flush_no_valid", {63'd0, saw_valid}, 64'd0);

        // DONE stalled 5 cycles, then one handoff with a request also present.
        issue(3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 5'h1A);
        wait_valid(lat);
        check("stall_latency", 64'(lat), 64'd65);
        held_data = 64'hFFFF_FFFF_FFFF_FFF1;
        for (int k = 0; k < 5; k++) begin
            @(posedge i_clk); #1;
            check($sformatf("stall%0d_valid", k), {63'd0, o_valid}, 64'd1);
            check($sformatf("stall%0d_data", k), o_rd_data, held_data);
            check($sformatf("stall%0d_addr", k), {59'd0, o_rd_addr}, 64'h1A);
        end
        i_ready = 1'b1; i_valid = 1'b1; i_op = 3'd5; i_word = 1'b0; i_rs2_rdata = 64'd0;
        @(posedge i_clk); #1;
        i_ready = 1'b0; i_valid = 1'b0;
        check("handoff_valid_drop", {63'd0, o_valid}, 64'd0);
        check("handoff_no_b2b", {63'd0, o_ready}, 64'd1);
        saw_valid = 1'b0;
        repeat (3) begin
            @(posedge i_clk); #1;
            saw_valid = saw_valid | o_valid;
        end
        check("single_handoff", {63'd0, saw_valid}, 64'd0);

        // Flush while a result waits in DONE
        issue(3'd4, 1'b0, 64'd7, 64'd0, 5'd3);
        check("dz_valid_now", {63'd0, o_valid}, 64'd1);
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        check("done_flush_valid", {63'd0, o_valid}, 64'd0);
        check("done_flush_ready", {63'd0, o_ready}, 64'd1);

        // Reset mid-CALC clears outputs at once and loses the operation
        issue(3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd17);
        repeat (5) begin @(posedge i_clk); #1; end
        i_rst_n = 1'b0;
        #2;
        check("mid_rst_valid", {63'd0, o_valid}, 64'd0);
        check("mid_rst_ready", {63'd0, o_ready}, 64'd1);
        check("mid_rst_data", o_rd_data, 64'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (80) begin
            @(posedge i_clk); #1;
            saw_valid = saw_valid | o_valid;
        end
        check("mid_rst_no_valid", {63'd0, saw_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width; legal values are 32 and 64.
REQ-002 SHALL have parameter RD_W, default 5, width of the destination-tag sideband.
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port i_valid  input  1  request valid.
REQ-006 SHALL have port o_ready  output  1  unit can accept a request.
REQ-007 SHALL have port i_op  input  3  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 SHALL have port i_word  input  1  32-bit W-variant; honoured only when XLEN=64 and i_op is in {0,4,5,6,7}, ignored otherwise.
REQ-009 SHALL have port i_rs1_rdata  input  XLEN  operand 1 (multiplicand or dividend).
REQ-010 SHALL have port i_rs2_rdata  input  XLEN  operand 2 (multiplier or divisor).
REQ-011 SHALL have port i_rd_addr  input  RD_W  destination tag.
REQ-012 SHALL have port i_flush  input  1  abort any in-flight operation.
REQ-013 SHALL have port o_valid  output  1  result valid.
REQ-014 SHALL have port i_ready  input  1  consumer accepts the result.
REQ-015 SHALL have port o_rd_data  output  XLEN  result.
REQ-016 SHALL have port o_rd_addr  output  RD_W  destination tag captured at accept.

Function
REQ-017 SHALL implement FSM states IDLE, CALC and DONE; o_ready=1 only in IDLE; o_valid=1 only in DONE.
REQ-018 SHALL accept a request on a cycle T where i_valid & o_ready & ~i_flush, and SHALL latch op, word, operands and rd_addr on that edge.
REQ-019 SHALL define N = 32 when the op is a word op, else XLEN.
REQ-020 SHALL iterate multiplication by radix-2 shift-add over N CALC cycles, on magnitudes, with the sign fix-up applied in the final cycle; the transition to DONE SHALL make o_valid=1 from T+N+1.
REQ-021 SHALL iterate division by radix-2 restoring division over N CALC cycles on magnitudes; quotient sign = sign(rs1) XOR sign(rs2), remainder sign = sign(rs1), for signed ops only; o_valid=1 from T+N+1.
REQ-022 SHALL give MUL (and MULW) the low XLEN bits of the product; MULH/MULHSU/MULHU SHALL give the high XLEN bits with signed x signed, signed x unsigned and unsigned x unsigned operands respectively.
REQ-023 SHALL, for word ops, use only operand bits [31:0] and sign-extend bit 31 of the 32-bit result to XLEN.
REQ-024 SHALL, on divide-by-zero (effective divisor 0), bypass CALC and go IDLE->DONE, giving o_valid at T+1 with quotient all-ones and remainder equal to the effective dividend (sign-extended for word ops).
REQ-025 SHALL, on signed overflow (dividend = most negative value of width N, divisor = -1), bypass CALC and go IDLE->DONE, giving o_valid at T+1 with quotient = dividend and remainder = 0.
REQ-026 SHALL, in DONE with i_ready=0, hold o_rd_data, o_rd_addr and o_valid stable; DONE & i_ready SHALL go to IDLE on the next edge, with no back-to-back accept in that same cycle.
REQ-027 SHALL, when i_flush=1, force the state to IDLE on the next edge from any state and drop any pending result; i_flush SHALL take priority over an accept and over i_ready.
REQ-028 SHALL treat changes on the request inputs outside the accept cycle as having no effect.
REQ-029 SHALL use an iteration counter of ceil(log2(XLEN+1)) bits that never wraps: it is loaded with N on accept and left unused in IDLE and DONE.

Reset
REQ-030 SHALL, on i_rst_n=0, asynchronously enter IDLE with o_valid=0, o_ready=1 after release, and o_rd_data=0, o_rd_addr=0, counter and internal registers 0.
REQ-031 SHALL, on reset asserted mid-CALC or in DONE, discard the operation, with no o_valid pulse after reset release.

Verification (XLEN=64)
REQ-032 SHALL pass: MUL rs1=3, rs2=0xFFFF_FFFF_FFFF_FFFB, accept at T -> o_valid at T+65, o_rd_data=0xFFFF_FFFF_FFFF_FFF1.
REQ-033 SHALL pass: MULHU rs1=rs2=0xFFFF_FFFF_FFFF_FFFF -> o_rd_data=0xFFFF_FFFF_FFFF_FFFE at T+65.
REQ-034 SHALL pass: DIV rs1=7, rs2=0 -> o_valid at T+1, o_rd_data=0xFFFF_FFFF_FFFF_FFFF; REM with the same operands -> 7.
REQ-035 SHALL pass: DIV rs1=0x8000_0000_0000_0000, rs2=0xFFFF_FFFF_FFFF_FFFF -> o_rd_data=0x8000_0000_0000_0000 at T+1; REM -> 0.
REQ-036 SHALL pass: DIVW rs1=0x0000_0001_FFFF_FFF9, rs2=2 -> o_valid at T+33, o_rd_data=0xFFFF_FFFF_FFFF_FFFD; REMW -> 0xFFFF_FFFF_FFFF_FFFF.
REQ-037 SHALL pass: i_flush at T+10 of a DIVU -> o_valid never asserted, o_ready=1 at T+11; i_ready held low 5 cycles in DONE -> result stable, single handoff.
